// File: rtl/cmd_frame_encoder.sv
// cmd_frame_encoder: framed, sequence-numbered, optionally LFSR-encrypted command byte stream.
// Revision 1.0
`default_nettype none

module cmd_frame_encoder #(
  parameter int         NUM_AXES      = 3,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         REPEAT_CYCLES = 3840000,
  parameter logic [7:0] KEY_SEED      = 8'h5A
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [2*NUM_AXES-1:0] axes,
  input  logic                  enc_en,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [6:0]            seq
);

  localparam int AW = 2 * NUM_AXES;
  localparam int P  = (AW + 7) / 8;
  localparam int CW = $clog2(REPEAT_CYCLES + 1);
  localparam int IW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(P - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    HDR  = 3'd2,
    PAY  = 3'd3,
    CSUM = 3'd4
  } state_t;

  state_t          state;
  logic            snap_mode;
  logic [AW-1:0]   snap_axes;
  logic            snap_enc;
  logic [CW-1:0]   rpt_cnt;
  logic            pending;
  logic [7:0]      lfsr;
  logic [7:0]      csum;
  logic [IW-1:0]   idx;

  logic            hs;
  logic            trigger;
  logic [7:0]      lfsr_next;
  logic [7:0]      key_next;
  logic [7:0]      hdr_byte;
  logic [8*P-1:0]  pay_vec;
  logic [IW-1:0]   load_idx;
  logic [7:0]      pay_byte;
  logic [7:0]      pay_enc;

  always_comb begin
    hs        = tx_valid && tx_ready;
    trigger   = pending || ({mode, axes} != {snap_mode, snap_axes}) || (rpt_cnt >= RPT_LAST);
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    // Payload bytes are keyed with the post-advance LFSR value because they
    // are loaded in the same cycle the previous byte's handshake advances it.
    key_next  = snap_enc ? lfsr_next : 8'h00;
    hdr_byte  = {snap_mode, seq} ^ (snap_enc ? lfsr : 8'h00);
    pay_vec   = '0;
    pay_vec[AW-1:0] = snap_axes;
    load_idx  = (state == PAY) ? idx + 1'b1 : '0;
    pay_byte  = 8'h00;
    for (int k = 0; k < P; k++) begin
      if (load_idx == IW'(k)) pay_byte = pay_vec[8*k +: 8];
    end
    pay_enc   = pay_byte ^ key_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tx_byte    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      seq        <= 7'd0;
      snap_mode  <= 1'b0;
      snap_axes  <= '0;
      snap_enc   <= 1'b0;
      rpt_cnt    <= '0;
      pending    <= 1'b1;
      lfsr       <= KEY_SEED;
      csum       <= 8'h00;
      idx        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (rpt_cnt != '1) rpt_cnt <= rpt_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (trigger) begin
            snap_mode <= mode;
            snap_axes <= axes;
            snap_enc  <= enc_en;
            rpt_cnt   <= '0;
            pending   <= 1'b0;
            tx_byte   <= SYNC_BYTE;
            tx_valid  <= 1'b1;
            busy      <= 1'b1;
            state     <= SYNC;
          end
        end
        SYNC: begin
          if (hs) begin
            tx_byte <= hdr_byte;
            csum    <= hdr_byte;
            state   <= HDR;
          end
        end
        HDR: begin
          if (hs) begin
            if (snap_enc) lfsr <= lfsr_next;
            tx_byte <= pay_enc;
            csum    <= csum ^ pay_enc;
            idx     <= '0;
            state   <= PAY;
          end
        end
        PAY: begin
          if (hs) begin
            if (snap_enc) lfsr <= lfsr_next;
            if (idx == LAST_IDX) begin
              tx_byte <= csum;
              state   <= CSUM;
            end else begin
              tx_byte <= pay_enc;
              csum    <= csum ^ pay_enc;
              idx     <= idx + 1'b1;
            end
          end
        end
        CSUM: begin
          if (hs) begin
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            seq        <= seq + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_frame_encoder.sv
// tb_cmd_frame_encoder: directed table-driven bench for cmd_frame_encoder.
// Revision 1.0
`default_nettype none

module tb_cmd_frame_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode = 1'b0;
  logic [5:0] axes = 6'd0;
  logic       enc_en = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       busy;
  logic       frame_done;
  logic [6:0] seq;

  cmd_frame_encoder #(
    .NUM_AXES(3),
    .SYNC_BYTE(8'hA5),
    .REPEAT_CYCLES(20),
    .KEY_SEED(8'h5A)
  ) dut (
    .clk(clk),
    .reset(reset_n),
    .mode(mode),
    .axes(axes),
    .enc_en(enc_en),
    .tx_byte(tx_byte),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .frame_done(frame_done),
    .seq(seq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_sync = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [5:0]  axes;
    logic        enc;
    logic [31:0] exp;
    logic [6:0]  seq_after;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk(name, {14'd0, tx_valid, busy, frame_done, seq, tx_byte}, 32'd0);
  endtask

  // Waits up to limit negedges for SYNC, then checks four bytes and the done cycle.
  task automatic check_frame(input string name, input logic [31:0] exp, input logic [6:0] exp_seq,
                             input int limit, input int stall_idx, input int stall_n,
                             input int chg_idx, input logic [5:0] chg_axes);
    logic       found;
    logic [7:0] eb;
    found = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (tx_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("%s_start", name), {31'd0, found}, 32'd1);
    if (!found) return;
    last_sync = cyc;
    for (int b = 0; b < 4; b++) begin
      eb = exp[31-8*b -: 8];
      chk($sformatf("%s_byte%0d", name, b), {23'd0, tx_valid, tx_byte}, {23'd0, 1'b1, eb});
      if (b == chg_idx) axes = chg_axes;
      if (b == stall_idx) begin
        tx_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk($sformatf("%s_hold%0d", name, s), {23'd0, tx_valid, tx_byte}, {23'd0, 1'b1, eb});
        end
        tx_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk($sformatf("%s_done", name), {22'd0, frame_done, busy, tx_valid, seq},
        {22'd0, 3'b100, exp_seq});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int s1;
    int s2;
    logic [7:0] h;
    logic [7:0] p;

    tbl[0] = '{1'b1, 1'b1, 6'h27, 1'b0, 32'hA5_80_27_A7, 7'd1};
    tbl[1] = '{1'b1, 1'b1, 6'h27, 1'b1, 32'hA5_DA_93_49, 7'd1};
    tbl[2] = '{1'b0, 1'b0, 6'h0D, 1'b1, 32'hA5_68_DF_B7, 7'd2};
    tbl[3] = '{1'b0, 1'b1, 6'h3F, 1'b0, 32'hA5_82_3F_BD, 7'd3};
    tbl[4] = '{1'b0, 1'b1, 6'h00, 1'b1, 32'hA5_27_48_6F, 7'd4};
    tbl[5] = '{1'b0, 1'b0, 6'h2A, 1'b1, 32'hA5_95_08_9D, 7'd5};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("initial_reset");

    for (int i = 0; i < 6; i++) begin
      mode   = tbl[i].mode;
      axes   = tbl[i].axes;
      enc_en = tbl[i].enc;
      if (tbl[i].rst) begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state($sformatf("vec%0d_reset", i));
        reset_n = 1'b1;
      end
      check_frame($sformatf("vec%0d", i), tbl[i].exp, tbl[i].seq_after, 2, -1, 0, -1, 6'd0);
    end

    // Backpressure on the payload byte, then keep-alive frames with constant inputs.
    mode = 1'b1; axes = 6'h27; enc_en = 1'b0;
    check_frame("bp", 32'hA5_85_27_A2, 7'd6, 40, 2, 5, -1, 6'd0);
    s0 = last_sync;
    check_frame("ka1", 32'hA5_86_27_A1, 7'd7, 40, -1, 0, -1, 6'd0);
    s1 = last_sync;
    chk("ka_period1", s1 - s0, 32'd20);
    check_frame("ka2", 32'hA5_87_27_A0, 7'd8, 40, -1, 0, -1, 6'd0);
    s2 = last_sync;
    chk("ka_period2", s2 - s1, 32'd20);

    // axis1 changes after the header; the frame in flight keeps the old payload.
    check_frame("chg", 32'hA5_88_27_AF, 7'd9, 40, -1, 0, 1, 6'h23);
    check_frame("after_chg", 32'hA5_89_23_AA, 7'd10, 2, -1, 0, -1, 6'd0);

    // Reset during PAY of an encrypted frame.
    enc_en = 1'b1; axes = 6'h27;
    @(negedge clk);
    chk("rst_mid_sync", {23'd0, tx_valid, tx_byte}, {23'd0, 1'b1, 8'hA5});
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_abort", {23'd0, tx_valid, busy, seq}, 32'd0);
    reset_n = 1'b1;
    check_frame("rst_frame", 32'hA5_DA_93_49, 7'd1, 2, -1, 0, -1, 6'd0);

    // Sequence wrap: frames seq 1..127, then the header field returns to 0.
    enc_en = 1'b0;
    for (int i = 1; i < 128; i++) begin
      axes = (i % 2 == 1) ? 6'h23 : 6'h27;
      h = {1'b1, 7'(i)};
      p = {2'b00, axes};
      check_frame($sformatf("wrap%0d", i), {8'hA5, h, p, h ^ p}, 7'((i + 1) % 128), 2, -1, 0, -1, 6'd0);
    end
    axes = 6'h27;
    check_frame("wrap_hdr0", 32'hA5_80_27_A7, 7'd1, 2, -1, 0, -1, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
